// File: rtl/gpio_ctrl_debounce.sv
// Per-pin glitch filter / debouncer on the GPIO input path.
// Two-flop sync, prescaled stability counters, change pulse.
module gpio_ctrl_debounce #(
  parameter int WIDTH = 256,
  parameter int CNT_W = 8,
  parameter int PRE_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [PRE_W-1:0] prescale,
  input  logic [CNT_W-1:0] threshold,
  input  logic [WIDTH-1:0] pad_in,
  output logic [WIDTH-1:0] filt_out,
  output logic [WIDTH-1:0] filt_changed
);

  localparam logic [PRE_W-1:0] PRE_ONE =
    {{(PRE_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE =
    {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W:0] CMP_ONE =
    {{CNT_W{1'b0}}, 1'b1};

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] filt_q, filt_d;
  logic [WIDTH-1:0] chg_q, chg_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic             strobe;
  logic             bypass;

  // >= so lowering prescale below pre_q fires on the next edge
  assign strobe = (pre_q >= prescale);
  assign pre_d  = strobe ? '0 : pre_q + PRE_ONE;
  assign bypass = !enable || (threshold == '0);

  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (bypass) begin
        filt_d[i] = sync2_q[i];
        cnt_d[i]  = '0;
      end else if (sync2_q[i] == filt_q[i]) begin
        cnt_d[i] = '0;
      end else if (strobe) begin
        if (({1'b0, cnt_q[i]} + CMP_ONE) >=
            {1'b0, threshold}) begin
          filt_d[i] = sync2_q[i];
          cnt_d[i]  = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
    chg_d = filt_d ^ filt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      filt_q  <= '0;
      chg_q   <= '0;
      pre_q   <= '0;
      for (int i = 0; i < WIDTH; i++)
        cnt_q[i] <= '0;
    end else begin
      sync1_q <= pad_in;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      chg_q   <= chg_d;
      pre_q   <= pre_d;
      for (int i = 0; i < WIDTH; i++)
        cnt_q[i] <= cnt_d[i];
    end
  end

  assign filt_out     = filt_q;
  assign filt_changed = chg_q;

endmodule

// File: doc/gpio_ctrl_debounce.md
# gpio_ctrl_debounce

Per-pin glitch filter and debouncer on the GPIO input path, directly upstream of the GPIO controller's `gpio_in_data` port. The block does three things:
- Synchronises raw pad inputs with two flops.
- Holds each pin's filtered value until the synchronised input has stayed different for a programmable number of prescaled sample strobes.
- Drives the filtered vector, plus a one-cycle per-bit change pulse, to the controller.

Contact bounce and short glitches therefore never reach the edge-detect/interrupt logic.

## Interface
Parameters:
- `WIDTH`, default 256: number of filtered pins (NUM_BANKS*32 at integration).
- `CNT_W`, default 8: width of per-pin stability counters and of `threshold`.
- `PRE_W`, default 16: width of the sample prescaler and of `prescale`.

Ports:
- `clk`  input  1  block clock, same clock as the GPIO controller.
- `rst_n`  input  1  reset; one clock; reset is synchronous and active-low.
- `enable`  input  1  1 = filtering active; 0 = bypass (filtered output follows synchronised input).
- `prescale`  input  PRE_W  sample strobe period minus one, in `clk` cycles.
- `threshold`  input  CNT_W  consecutive strobes of stable mismatch needed to accept a new level; 0 = bypass.
- `pad_in`  input  WIDTH  raw asynchronous pad inputs.
- `filt_out`  output  WIDTH  debounced level, feeds controller `gpio_in_data`.
- `filt_changed`  output  WIDTH  per-bit one-cycle pulse, high in the cycle `filt_out[i]` takes a new value.

## Operation
Synchroniser:
- `pad_in` passes through two flops per bit, giving `sync[i]`.

Prescaler:
- `pre_cnt` (PRE_W bits); `strobe = (pre_cnt >= prescale)`.
- On `strobe`, `pre_cnt <= 0`; otherwise `pre_cnt <= pre_cnt + 1`.
- `prescale = 0` gives a strobe every cycle.
- Lowering `prescale` below the current `pre_cnt` fires a strobe on the next edge. No wrap past the maximum is possible.
- The prescaler free-runs regardless of `enable`.

Per-bit filter (`cnt[i]`, CNT_W bits), evaluated every clock edge when `enable=1` and `threshold != 0`:
- If `sync[i] == filt_out[i]`: `cnt[i] <= 0`. Any single-cycle return to the held level cancels the pending change, even between strobes.
- Else, if no strobe: `cnt[i]` holds.
- Else, if strobe and `cnt[i] + 1 >= threshold` (compare computed at CNT_W+1 bits, no overflow): `filt_out[i] <= sync[i]`, `cnt[i] <= 0`.
- Else, if strobe: `cnt[i] <= cnt[i] + 1`.
- Because the compare uses `>=`, lowering `threshold` mid-count takes effect at the next strobe. The counter never exceeds `threshold - 1`, so it never saturates.

Bypass (`enable=0` or `threshold=0`):
- `filt_out <= sync` every cycle; all `cnt <= 0`.
- Leaving bypass starts filtering from the current `filt_out`, with zero count.

Change pulse:
- `filt_changed[i] <= (next filt_out[i] != filt_out[i])`. Registered, so it is high in the same cycle as the new `filt_out` value. This holds in bypass too.

Bits are fully independent. No cross-bit interaction.

## Timing
Reset (`rst_n` low at a clock edge):
- Sync flops, `filt_out`, `filt_changed`, all `cnt` and `pre_cnt` become 0.
- Reset mid-count discards pending changes.
- The first strobe after reset release occurs `prescale` cycles after the first non-reset edge.

Bypass latency:
- `pad_in` change to `filt_out` is 3 clock edges (2 sync + 1 output register).

Filtered latency:
- `sync` change is visible after 2 edges.
- `filt_out` updates on the edge of the `threshold`-th strobe at which mismatch is still present, counted from the first strobe after mismatch began.
- With continuous strobes (`prescale=0`): 2 + `threshold` edges.

Pulse timing:
- `filt_changed` is a single cycle.
- Back-to-back toggles in bypass give back-to-back pulses.

Handshake:
- None. Outputs are level/pulse, with no backpressure.

## Test plan
- Reset: drive `pad_in`=all ones during reset; after release `filt_out`=0 and `filt_changed`=0. With `enable=0`, `filt_out`=all ones at edge 3 and `filt_changed`=all ones for exactly one cycle.
- Clean edge: `prescale=0`, `threshold=4`, `enable=1`; raise `pad_in[5]` and hold. `filt_out[5]` rises exactly 6 edges later, `filt_changed[5]` pulses once, and all other bits stay 0.
- Glitch rejection: same config; pulse `pad_in[7]` high for 3 cycles, then low. `filt_out[7]` stays 0 and `filt_changed` never asserts. Repeat with 4 cycles: `filt_out[7]` rises.
- Prescaled: `prescale=9`, `threshold=3`; a step on `pad_in[0]` is accepted on the 3rd strobe after mismatch. A 1-cycle dip between strobes resets the count, so acceptance needs 3 further strobes.
- Mid-operation changes: with `cnt=5` at `threshold=10`, write `threshold=3`; `filt_out` updates on the next strobe. Assert `rst_n` low mid-count; the count is discarded and `filt_out`=0.
- Bypass/threshold 0: `threshold=0`; toggle `pad_in[255]` every cycle. `filt_out[255]` mirrors the toggles with 3-cycle delay, and `filt_changed[255]` stays high continuously.
